// File: rtl/card_draw_pkg.sv
// Shared types and helpers for the card draw unit: debouncer states,
// LFSR polynomial, default seed and the card scaling function.
package card_draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } deb_state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          SCALE_BITS   = 8;

  // Right-shifting Galois step; a nonzero register never becomes zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Maps a raw byte onto 1..card_max: floor(raw*card_max/256)+1.
  // 13 bits hold the largest product (255*31).
  function automatic logic [4:0] scale_card(input logic [7:0] raw,
                                            input logic [4:0] card_max);
    logic [12:0] prod;
    prod = 13'(raw) * 13'(card_max);
    return 5'(prod >> SCALE_BITS) + 5'd1;
  endfunction

endpackage

// File: rtl/card_draw_unit_key_debouncer.sv
// Turns a raw active-low push button into a single accept pulse per
// physical press, ignoring bounces shorter than DEBOUNCE_CYCLES.
module key_debouncer
  import card_draw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic accept,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             key_s;
  deb_state_t       state;
  deb_state_t       next_state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] next_counter;

  // Two-flop synchroniser; idles high so reset looks like a released key.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      key_s     <= 1'b1;
    end else begin
      sync_meta <= key_n;
      key_s     <= sync_meta;
    end
  end

  // State, stability counter and busy flag all update on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      counter <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
      busy    <= (next_state == ST_PRESS_WAIT) || (next_state == ST_RELEASE_WAIT);
    end
  end

  // Next-state logic; accept fires in the cycle the press becomes stable.
  always_comb begin
    next_state   = state;
    next_counter = counter;
    accept       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!key_s) begin
          next_state   = ST_PRESS_WAIT;
          next_counter = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (key_s) begin
          next_state = ST_IDLE;
        end else if (counter == LAST_COUNT) begin
          next_state = ST_HELD;
          accept     = 1'b1;
        end else begin
          next_counter = counter + 1'b1;
        end
      end
      ST_HELD: begin
        if (key_s) begin
          next_state   = ST_RELEASE_WAIT;
          next_counter = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!key_s) begin
          next_state = ST_HELD;
        end else if (counter == LAST_COUNT) begin
          next_state = ST_IDLE;
        end else begin
          next_counter = counter + 1'b1;
        end
      end
      default: begin
        next_state   = ST_IDLE;
        next_counter = '0;
      end
    endcase
  end

endmodule

// File: rtl/card_draw_unit.sv
// Card source for the game mux: debounced key press draws a card value
// 1..CARD_MAX from a free-running LFSR, with a valid pulse and a
// saturating draw counter.
module card_draw_unit
  import card_draw_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          CNT_W           = 20,
  parameter int          CARD_MAX        = 13,
  parameter logic [15:0] SEED            = DEFAULT_SEED
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       key_n,
  output logic [4:0] q,
  output logic       draw_valid,
  output logic [3:0] draw_count,
  output logic       busy
);

  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [4:0]  CARD_MAX_W = 5'(CARD_MAX);

  logic [15:0] lfsr;
  logic        accept;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debouncer (
    .clock  (clock),
    .reset_n(reset_n),
    .key_n  (key_n),
    .accept (accept),
    .busy   (busy)
  );

  // Free-running random source, independent of enable and key activity.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Commit a draw on an accepted press; a disabled press is simply dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q          <= 5'd0;
      draw_valid <= 1'b0;
      draw_count <= 4'd0;
    end else if (accept && enable) begin
      q          <= scale_card(lfsr[7:0], CARD_MAX_W);
      draw_valid <= 1'b1;
      if (draw_count != 4'hF) begin
        draw_count <= draw_count + 4'd1;
      end
    end else begin
      draw_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_card_draw_unit.sv
// Directed bench for card_draw_unit with a 4-cycle debounce window.
module tb_card_draw_unit;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       key_n;
  logic [4:0] q;
  logic       draw_valid;
  logic [3:0] draw_count;
  logic       busy;

  int errors;
  int checks;
  int pulse_count;
  int pulse_base;
  int exp_q;
  int exp_count;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  card_draw_unit #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .CARD_MAX       (13),
    .SEED           (16'hACE1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .key_n     (key_n),
    .q         (q),
    .draw_valid(draw_valid),
    .draw_count(draw_count),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference LFSR; m_prev holds the value the DUT used at the latest edge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Count every valid pulse seen mid-cycle.
  always @(negedge clock) begin
    if (draw_valid === 1'b1) pulse_count++;
  end

  function automatic int model_scale(input logic [7:0] b);
    int prod;
    prod = int'(b) * 13;
    return (prod / 256) + 1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    key_n   = 1'b1;
    enable  = 1'b1;
    repeat (2) tick();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) tick();
    exp_q     = 0;
    exp_count = 0;
  endtask

  // Press and hold: draw expected at edge k+6 when exp_draw is set.
  task automatic apply_stimulus(input bit exp_draw);
    key_n = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      check_output("busy_press", 32'(busy), 32'((i >= 2 && i <= 5) ? 1 : 0));
      if (i < 6) check_output("dv_early", 32'(draw_valid), 32'd0);
    end
    if (exp_draw) begin
      exp_q = model_scale(m_prev[7:0]);
      if (exp_count < 15) exp_count++;
    end
    check_output("dv_commit", 32'(draw_valid), 32'(exp_draw));
    check_output("q_commit", 32'(q), 32'(exp_q));
    check_output("count_commit", 32'(draw_count), 32'(exp_count));
    tick();
    check_output("dv_one_cycle", 32'(draw_valid), 32'd0);
  endtask

  task automatic do_release();
    key_n = 1'b1;
    repeat (8) tick();
    check_output("busy_released", 32'(busy), 32'd0);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    pulse_count = 0;
    reset_n     = 1'b0;
    key_n       = 1'b1;
    enable      = 1'b1;
    #2;
    check_output("rst_q", 32'(q), 32'd0);
    check_output("rst_dv", 32'(draw_valid), 32'd0);
    check_output("rst_count", 32'(draw_count), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);

    // 1: single clean press
    $display("[TB] test 1: clean press");
    do_reset();
    apply_stimulus(1'b1);
    check_output("t1_q_nonzero", 32'(q != 5'd0), 32'd1);
    do_release();

    // 2: 2-cycle bounces never complete a press
    $display("[TB] test 2: short bounces");
    do_reset();
    pulse_base = pulse_count;
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      repeat (2) tick();
      key_n = 1'b1;
      repeat (2) tick();
    end
    repeat (6) tick();
    check_output("t2_pulses", 32'(pulse_count - pulse_base), 32'd0);
    check_output("t2_count", 32'(draw_count), 32'd0);
    check_output("t2_busy", 32'(busy), 32'd0);
    check_output("t2_q", 32'(q), 32'd0);

    // 3: release glitches while held give no second draw
    $display("[TB] test 3: glitches while held");
    do_reset();
    pulse_base = pulse_count;
    apply_stimulus(1'b1);
    for (int g = 0; g < 2; g++) begin
      key_n = 1'b1;
      repeat (3) tick();
      key_n = 1'b0;
      repeat (4) tick();
      check_output("t3_busy_held", 32'(busy), 32'd0);
    end
    do_release();
    check_output("t3_pulses", 32'(pulse_count - pulse_base), 32'd1);
    check_output("t3_count", 32'(draw_count), 32'd1);
    check_output("t3_q", 32'(q), 32'(exp_q));

    // 4: disabled press is consumed without drawing
    $display("[TB] test 4: enable low");
    do_reset();
    enable = 1'b0;
    apply_stimulus(1'b0);
    do_release();
    check_output("t4_q_idle", 32'(q), 32'd0);
    check_output("t4_count_idle", 32'(draw_count), 32'd0);
    enable = 1'b1;
    apply_stimulus(1'b1);
    do_release();
    check_output("t4_count_after", 32'(draw_count), 32'd1);

    // 5: counter saturation and value range
    $display("[TB] test 5: saturation");
    do_reset();
    for (int p = 1; p <= 17; p++) begin
      apply_stimulus(1'b1);
      check_output("t5_q_range", 32'(q >= 5'd1 && q <= 5'd13), 32'd1);
      if (p >= 15) check_output("t5_count_sat", 32'(draw_count), 32'd15);
      do_release();
    end
    check_output("t5_scale_00", 32'(card_draw_pkg::scale_card(8'h00, 5'd13)), 32'd1);
    check_output("t5_scale_ff", 32'(card_draw_pkg::scale_card(8'hFF, 5'd13)), 32'd13);
    check_output("t5_scale_80", 32'(card_draw_pkg::scale_card(8'h80, 5'd13)), 32'd7);

    // 6: reset mid-debounce, key held through release
    $display("[TB] test 6: reset during debounce");
    do_reset();
    apply_stimulus(1'b1);
    do_release();
    key_n = 1'b0;
    repeat (5) tick();
    check_output("t6_busy_pw", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_q", 32'(q), 32'd0);
    check_output("t6_rst_dv", 32'(draw_valid), 32'd0);
    check_output("t6_rst_count", 32'(draw_count), 32'd0);
    check_output("t6_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    @(negedge clock);
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) check_output("t6_dv_wait", 32'(draw_valid), 32'd0);
    end
    check_output("t6_dv", 32'(draw_valid), 32'd1);
    check_output("t6_count", 32'(draw_count), 32'd1);
    check_output("t6_q", 32'(q), 32'(model_scale(m_prev[7:0])));
    do_release();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
